// File: rtl/fetch_inject_ctrl_pkg.sv
// Shared definitions for the fetch-buffer injection controller: FSM state
// encoding and the opcode values that trigger or fill injected slots.
package fetch_inject_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CALL,
        RET,
        RTI1,
        RTI2,
        LDM,
        NOP1,
        INT3,
        INT2,
        INT1
    } state_t;

    localparam logic [4:0] OP_NOP       = 5'b00000;
    localparam logic [4:0] OP_LDM       = 5'b10010;
    localparam logic [4:0] OP_CALL      = 5'b11000;
    localparam logic [4:0] OP_RET       = 5'b11001;
    localparam logic [4:0] OP_RTI       = 5'b11010;
    localparam logic [4:0] PUSH_PC_HIGH = 5'b10110;
    localparam logic [4:0] POP_PC_LOW   = 5'b10111;
    localparam logic [4:0] POP_FLAGS    = 5'b01111;

endpackage

// File: rtl/fetch_inject_ctrl.sv
// Sequences injected fetch-buffer slots for CALL/RET/RTI/LDM and runs the
// three-slot interrupt entry; outputs are a pure decode of the state register.
module fetch_inject_ctrl
    import fetch_inject_ctrl_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] inst_op,
    input  logic           inst_valid,
    input  logic           stall,
    input  logic           int_req,
    output logic           cs_call,
    output logic           cs_ret,
    output logic           cs_rti,
    output logic           previous_rti,
    output logic           fetch_NOP,
    output logic           cs_ldm,
    output logic           pc_hold,
    output logic [1:0]     int_cnt,
    output logic           int_ack
);

    state_t state;
    state_t state_next;
    logic   pending;
    logic   in_int;

    assign in_int = (state == INT3) || (state == INT2) || (state == INT1);

    // Decoded opcodes only matter in IDLE; other slots hold injected content.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (inst_valid && inst_op == OPW'(OP_CALL))
                    state_next = CALL;
                else if (inst_valid && inst_op == OPW'(OP_RET))
                    state_next = RET;
                else if (inst_valid && inst_op == OPW'(OP_RTI))
                    state_next = RTI1;
                else if (inst_valid && inst_op == OPW'(OP_LDM))
                    state_next = LDM;
                else if (pending || int_req)
                    state_next = INT3;
                else
                    state_next = IDLE;
            end
            CALL:    state_next = NOP1;
            RET:     state_next = NOP1;
            RTI1:    state_next = RTI2;
            RTI2:    state_next = NOP1;
            LDM:     state_next = IDLE;
            NOP1:    state_next = IDLE;
            INT3:    state_next = INT2;
            INT2:    state_next = INT1;
            INT1:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pending still captures requests while stalled so none are lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= 1'b0;
        end else begin
            if (!stall)
                state <= state_next;
            if (!stall && state == IDLE && state_next == INT3)
                pending <= 1'b0;
            else if (int_req && !in_int)
                pending <= 1'b1;
        end
    end

    always_comb begin
        cs_call      = 1'b0;
        cs_ret       = 1'b0;
        cs_rti       = 1'b0;
        previous_rti = 1'b0;
        fetch_NOP    = 1'b0;
        cs_ldm       = 1'b0;
        pc_hold      = 1'b0;
        int_cnt      = 2'b00;
        int_ack      = 1'b0;
        unique case (state)
            CALL: begin
                cs_call = 1'b1;
                pc_hold = 1'b1;
            end
            RET: begin
                cs_ret  = 1'b1;
                pc_hold = 1'b1;
            end
            RTI1: begin
                cs_rti  = 1'b1;
                pc_hold = 1'b1;
            end
            RTI2: begin
                previous_rti = 1'b1;
                pc_hold      = 1'b1;
            end
            LDM: begin
                fetch_NOP = 1'b1;
                cs_ldm    = 1'b1;
            end
            NOP1: begin
                fetch_NOP = 1'b1;
                pc_hold   = 1'b1;
            end
            INT3: begin
                fetch_NOP = 1'b1;
                pc_hold   = 1'b1;
                int_cnt   = 2'b11;
                int_ack   = 1'b1;
            end
            INT2: begin
                fetch_NOP = 1'b1;
                pc_hold   = 1'b1;
                int_cnt   = 2'b10;
            end
            INT1: begin
                fetch_NOP = 1'b1;
                pc_hold   = 1'b1;
                int_cnt   = 2'b01;
            end
            default: begin
                cs_call = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_inject_ctrl.sv
// Scoreboard bench for fetch_inject_ctrl: each directed vector queues the
// output word expected after the next clock edge; a monitor pops and compares.
module tb_fetch_inject_ctrl;
    import fetch_inject_ctrl_pkg::*;

    // Output word order: cs_call cs_ret cs_rti previous_rti fetch_NOP cs_ldm pc_hold int_cnt[1:0] int_ack
    localparam logic [9:0] E_ZERO = 10'b0_0_0_0_0_0_0_00_0;
    localparam logic [9:0] E_CALL = 10'b1_0_0_0_0_0_1_00_0;
    localparam logic [9:0] E_RET  = 10'b0_1_0_0_0_0_1_00_0;
    localparam logic [9:0] E_RTI1 = 10'b0_0_1_0_0_0_1_00_0;
    localparam logic [9:0] E_RTI2 = 10'b0_0_0_1_0_0_1_00_0;
    localparam logic [9:0] E_LDM  = 10'b0_0_0_0_1_1_0_00_0;
    localparam logic [9:0] E_NOP1 = 10'b0_0_0_0_1_0_1_00_0;
    localparam logic [9:0] E_INT3 = 10'b0_0_0_0_1_0_1_11_1;
    localparam logic [9:0] E_INT2 = 10'b0_0_0_0_1_0_1_10_0;
    localparam logic [9:0] E_INT1 = 10'b0_0_0_0_1_0_1_01_0;

    typedef struct {
        logic [9:0] val;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] inst_op;
    logic       inst_valid;
    logic       stall;
    logic       int_req;
    logic       cs_call, cs_ret, cs_rti, previous_rti, fetch_NOP, cs_ldm, pc_hold, int_ack;
    logic [1:0] int_cnt;
    logic [9:0] obs;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    assign obs = {cs_call, cs_ret, cs_rti, previous_rti, fetch_NOP, cs_ldm,
                  pc_hold, int_cnt, int_ack};

    fetch_inject_ctrl #(.OPW(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_op     (inst_op),
        .inst_valid  (inst_valid),
        .stall       (stall),
        .int_req     (int_req),
        .cs_call     (cs_call),
        .cs_ret      (cs_ret),
        .cs_rti      (cs_rti),
        .previous_rti(previous_rti),
        .fetch_NOP   (fetch_NOP),
        .cs_ldm      (cs_ldm),
        .pc_hold     (pc_hold),
        .int_cnt     (int_cnt),
        .int_ack     (int_ack)
    );

    task automatic checkOutput(input string name, input logic [9:0] expv);
        checks++;
        if (obs === expv)
            passed++;
        else
            $display("[TB] FAIL %s: got %b expected %b", name, obs, expv);
    endtask

    task automatic applyStimulus(input string name, input logic r, input logic s,
                                 input logic v, input logic [4:0] op,
                                 input logic irq, input logic [9:0] expv);
        exp_t t;
        @(negedge clk);
        rst        = r;
        stall      = s;
        inst_valid = v;
        inst_op    = op;
        int_req    = irq;
        t.val  = expv;
        t.name = name;
        sb.push_back(t);
    endtask

    task automatic idleCycle(input string name, input logic [9:0] expv);
        applyStimulus(name, 1'b0, 1'b0, 1'b0, OP_NOP, 1'b0, expv);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput(e.name, e.val);
            end
        end
    end

    initial begin
        rst        = 1'b1;
        stall      = 1'b0;
        inst_valid = 1'b0;
        inst_op    = OP_NOP;
        int_req    = 1'b0;

        applyStimulus("reset0", 1, 0, 0, OP_NOP, 0, E_ZERO);
        applyStimulus("reset1", 1, 0, 1, OP_CALL, 1, E_ZERO);

        applyStimulus("call_slot", 0, 0, 1, OP_CALL, 0, E_CALL);
        idleCycle("call_nop1", E_NOP1);
        idleCycle("call_idle", E_ZERO);

        applyStimulus("rti_slot1", 0, 0, 1, OP_RTI, 0, E_RTI1);
        idleCycle("rti_slot2", E_RTI2);
        idleCycle("rti_nop1", E_NOP1);
        idleCycle("rti_idle", E_ZERO);

        applyStimulus("ldm_slot", 0, 0, 1, OP_LDM, 0, E_LDM);
        applyStimulus("ldm_ignores_op", 0, 0, 1, OP_CALL, 0, E_ZERO);

        applyStimulus("plain_nop", 0, 0, 1, OP_NOP, 0, E_ZERO);
        applyStimulus("plain_push", 0, 0, 1, PUSH_PC_HIGH, 0, E_ZERO);
        applyStimulus("invalid_call", 0, 0, 0, OP_CALL, 0, E_ZERO);

        applyStimulus("ret_slot", 0, 0, 1, OP_RET, 0, E_RET);
        applyStimulus("ret_irq_nop1", 0, 0, 0, OP_NOP, 1, E_NOP1);
        idleCycle("ret_idle", E_ZERO);
        idleCycle("ret_int3", E_INT3);
        idleCycle("ret_int2", E_INT2);
        idleCycle("ret_int1", E_INT1);
        idleCycle("ret_int_done", E_ZERO);

        applyStimulus("both_call", 0, 0, 1, OP_CALL, 1, E_CALL);
        idleCycle("both_nop1", E_NOP1);
        idleCycle("both_idle", E_ZERO);
        idleCycle("both_int3", E_INT3);
        idleCycle("both_int2", E_INT2);
        idleCycle("both_int1", E_INT1);
        idleCycle("both_done", E_ZERO);

        applyStimulus("nest_int3", 0, 0, 0, OP_NOP, 1, E_INT3);
        applyStimulus("nest_int2", 0, 0, 1, OP_CALL, 1, E_INT2);
        applyStimulus("nest_int1", 0, 0, 0, OP_NOP, 1, E_INT1);
        idleCycle("nest_done", E_ZERO);
        idleCycle("nest_no_reentry", E_ZERO);

        applyStimulus("rst_int3", 0, 0, 0, OP_NOP, 1, E_INT3);
        idleCycle("rst_int2", E_INT2);
        applyStimulus("rst_in_int2", 1, 0, 0, OP_NOP, 0, E_ZERO);
        idleCycle("rst_stays_idle", E_ZERO);
        applyStimulus("rst_later_int3", 0, 0, 0, OP_NOP, 1, E_INT3);
        idleCycle("rst_later_int2", E_INT2);
        idleCycle("rst_later_int1", E_INT1);
        idleCycle("rst_later_done", E_ZERO);

        applyStimulus("stall_call", 0, 0, 1, OP_CALL, 0, E_CALL);
        applyStimulus("stall_hold", 0, 1, 1, OP_RET, 1, E_CALL);
        idleCycle("stall_nop1", E_NOP1);
        idleCycle("stall_idle", E_ZERO);
        idleCycle("stall_int3", E_INT3);
        applyStimulus("stall_int3_hold", 0, 1, 0, OP_NOP, 0, E_INT3);
        idleCycle("stall_int2", E_INT2);
        idleCycle("stall_int1", E_INT1);
        idleCycle("stall_done", E_ZERO);

        applyStimulus("rstdom_rti1", 0, 0, 1, OP_RTI, 0, E_RTI1);
        applyStimulus("rstdom_clear", 1, 1, 0, OP_NOP, 0, E_ZERO);
        idleCycle("rstdom_idle", E_ZERO);

        begin
            int budget;
            budget = 0;
            while (sb.size() > 0 && budget < 20) begin
                @(posedge clk);
                budget++;
            end
            #2;
            if (sb.size() > 0) begin
                checks++;
                $display("[TB] FAIL drain: %0d expectations left, required 0", sb.size());
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
